sha256_msg_schedule: RTL and testbench

- Upstream neighbour of the SHA-256 round engine; produces the per-round message word W_t it consumes on its in_w input.
- Accepts one 512-bit padded block as 16 serial 32-bit words, then streams W_0..W_63 one per advance.
- Uses a 16-word sliding window; W_16..W_63 are expanded on the fly with the small-sigma functions.

---
 rtl/sha256_pkg.sv | 48 ++++
 rtl/sha256_small_sigma.sv | 13 +
 rtl/sha256_msg_schedule.sv | 111 +++++++++++
 tb/tb_sha256_msg_schedule.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/sha256_pkg.sv
// rtl/sha256_pkg.sv - shared SHA-256 types, constants and bit-mixing functions
package sha256_pkg;

    localparam int WORD_W     = 32;
    localparam int ROUNDS_DEF = 64;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } sched_state_e;

    function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x, input int unsigned n);
        rotr = (x >> n) | (x << (WORD_W - n));
    endfunction

    // Message-schedule mixers
    function automatic logic [WORD_W-1:0] small_sigma0(input logic [WORD_W-1:0] x);
        small_sigma0 = rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [WORD_W-1:0] small_sigma1(input logic [WORD_W-1:0] x);
        small_sigma1 = rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    // Round-engine mixers
    function automatic logic [WORD_W-1:0] big_sigma0(input logic [WORD_W-1:0] x);
        big_sigma0 = rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [WORD_W-1:0] big_sigma1(input logic [WORD_W-1:0] x);
        big_sigma1 = rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [WORD_W-1:0] ch(input logic [WORD_W-1:0] x,
                                             input logic [WORD_W-1:0] y,
                                             input logic [WORD_W-1:0] z);
        ch = (x & y) ^ (~x & z);
    endfunction

    function automatic logic [WORD_W-1:0] maj(input logic [WORD_W-1:0] x,
                                              input logic [WORD_W-1:0] y,
                                              input logic [WORD_W-1:0] z);
        maj = (x & y) ^ (x & z) ^ (y & z);
    endfunction

endpackage

// File: rtl/sha256_small_sigma.sv
// rtl/sha256_small_sigma.sv - combinational sigma0/sigma1 of one 32-bit word
module sha256_small_sigma
    import sha256_pkg::*;
(
    input  logic [WORD_W-1:0] x,
    output logic [WORD_W-1:0] s0,
    output logic [WORD_W-1:0] s1
);

    assign s0 = small_sigma0(x);
    assign s1 = small_sigma1(x);

endmodule

// File: rtl/sha256_msg_schedule.sv
// rtl/sha256_msg_schedule.sv - loads a 16-word block and streams W_0..W_(ROUNDS-1)
module sha256_msg_schedule
    import sha256_pkg::*;
#(
    parameter int ROUNDS = ROUNDS_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [WORD_W-1:0] in_w,
    output logic              in_ready,
    input  logic              next,
    output logic              out_valid,
    output logic [WORD_W-1:0] out_w,
    output logic [5:0]        out_idx,
    output logic              busy,
    output logic              done
);

    localparam logic [5:0] LAST_T = 6'(ROUNDS - 1);

    sched_state_e                 state_q, state_d;
    logic [15:0][WORD_W-1:0]      window_q, window_d;
    logic [3:0]                   load_cnt_q, load_cnt_d;
    logic [5:0]                   t_q, t_d;

    logic [WORD_W-1:0] s0_w1, s1_w1_unused;
    logic [WORD_W-1:0] s0_w14_unused, s1_w14;
    logic [WORD_W-1:0] expand_w;

    sha256_small_sigma u_sigma_w1 (
        .x  (window_q[1]),
        .s0 (s0_w1),
        .s1 (s1_w1_unused)
    );

    sha256_small_sigma u_sigma_w14 (
        .x  (window_q[14]),
        .s0 (s0_w14_unused),
        .s1 (s1_w14)
    );

    // W_(t+16) from the current window, where window[0] holds W_t
    assign expand_w = s1_w14 + window_q[9] + s0_w1 + window_q[0];

    always_comb begin
        state_d    = state_q;
        window_d   = window_q;
        load_cnt_d = load_cnt_q;
        t_d        = t_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_LOAD;
                    load_cnt_d = 4'd0;
                end
            end
            ST_LOAD: begin
                if (in_valid) begin
                    window_d   = {in_w, window_q[15:1]};
                    load_cnt_d = load_cnt_q + 4'd1;
                    if (load_cnt_q == 4'd15) begin
                        state_d = ST_RUN;
                        t_d     = 6'd0;
                    end
                end
            end
            ST_RUN: begin
                if (next) begin
                    window_d = {expand_w, window_q[15:1]};
                    if (t_q == LAST_T) begin
                        state_d = ST_DONE;
                    end else begin
                        t_d = t_q + 6'd1;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                t_d     = 6'd0;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            window_q   <= '0;
            load_cnt_q <= 4'd0;
            t_q        <= 6'd0;
        end else begin
            state_q    <= state_d;
            window_q   <= window_d;
            load_cnt_q <= load_cnt_d;
            t_q        <= t_d;
        end
    end

    // Outputs are state-gated so they read zero outside RUN, including during reset
    always_comb begin
        in_ready  = (state_q == ST_LOAD);
        out_valid = (state_q == ST_RUN);
        out_w     = (state_q == ST_RUN) ? window_q[0] : '0;
        out_idx   = (state_q == ST_RUN) ? t_q : 6'd0;
        busy      = (state_q == ST_LOAD) || (state_q == ST_RUN);
        done      = (state_q == ST_DONE);
    end

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// tb/tb_sha256_msg_schedule.sv - directed self-checking bench for sha256_msg_schedule
module tb_sha256_msg_schedule;

    logic        clk = 1'b0;
    logic        reset;
    logic        start, in_valid, next;
    logic [31:0] in_w;
    logic        in_ready, out_valid, busy, done;
    logic [31:0] out_w;
    logic [5:0]  out_idx;

    logic        s_start, s_in_valid, s_next;
    logic [31:0] s_in_w;
    logic        s_in_ready, s_out_valid, s_busy, s_done;
    logic [31:0] s_out_w;
    logic [5:0]  s_out_idx;

    int checks = 0;
    int errors = 0;

    logic [31:0] blk   [16];
    logic [31:0] exp_w [64];

    always #5 clk = ~clk;

    sha256_msg_schedule #(.ROUNDS(64)) dut (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_w(in_w),
        .in_ready(in_ready), .next(next), .out_valid(out_valid), .out_w(out_w),
        .out_idx(out_idx), .busy(busy), .done(done)
    );

    sha256_msg_schedule #(.ROUNDS(16)) dut16 (
        .clk(clk), .reset(reset), .start(s_start), .in_valid(s_in_valid), .in_w(s_in_w),
        .in_ready(s_in_ready), .next(s_next), .out_valid(s_out_valid), .out_w(s_out_w),
        .out_idx(s_out_idx), .busy(s_busy), .done(s_done)
    );

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Reference schedule in the textbook W[t] form
    task automatic build_exp();
        for (int t = 0; t < 64; t++) begin
            if (t < 16) exp_w[t] = blk[t];
            else exp_w[t] = (ror(exp_w[t-2], 17) ^ ror(exp_w[t-2], 19) ^ (exp_w[t-2] >> 10))
                          + exp_w[t-7]
                          + (ror(exp_w[t-15], 7) ^ ror(exp_w[t-15], 18) ^ (exp_w[t-15] >> 3))
                          + exp_w[t-16];
        end
    endtask

    task automatic set_abc();
        for (int i = 0; i < 16; i++) blk[i] = 32'h0;
        blk[0]  = 32'h61626380;
        blk[15] = 32'h00000018;
        build_exp();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic do_load(input bit stall_mid, input bit start_mid);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (stall_mid && i == 8) begin
                in_valid = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    chk("load_stall_ready", 32'(in_ready), 32'd1);
                    chk("load_stall_cnt", 32'(dut.load_cnt_q), 32'd8);
                end
            end
            chk("load_ready", 32'(in_ready), 32'd1);
            in_valid = 1'b1;
            in_w     = blk[i];
            if (start_mid && i == 4) start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        in_valid = 1'b0;
    endtask

    task automatic do_stream(input bit stall20, input bit start_mid);
        for (int t = 0; t < 64; t++) begin
            if (stall20 && t == 20) begin
                next = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    chk("stall_w", out_w, exp_w[20]);
                    chk("stall_idx", 32'(out_idx), 32'd20);
                    chk("stall_valid", 32'(out_valid), 32'd1);
                end
            end
            chk("run_valid", 32'(out_valid), 32'd1);
            chk("run_idx", 32'(out_idx), 32'(t));
            chk("run_w", out_w, exp_w[t]);
            chk("run_done_low", 32'(done), 32'd0);
            next = 1'b1;
            if (start_mid && t == 10) start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        chk("done_pulse", 32'(done), 32'd1);
        chk("done_valid_low", 32'(out_valid), 32'd0);
        @(negedge clk);
        next = 1'b0;
        chk("done_once", 32'(done), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_valid", 32'(out_valid), 32'd0);
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; in_valid = 1'b0; next = 1'b0; in_w = 32'h0;
        s_start = 1'b0; s_in_valid = 1'b0; s_next = 1'b0; s_in_w = 32'h0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_w", out_w, 32'd0);
        chk("rst_out_idx", 32'(out_idx), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        reset = 1'b1;

        // "abc" block, no stalls, with fixed known words
        set_abc();
        chk("abc_w16_const", exp_w[16], 32'h61626380);
        chk("abc_w17_const", exp_w[17], 32'h000F0000);
        do_load(1'b0, 1'b0);
        chk("abc_first_w0", out_w, 32'h61626380);
        do_stream(1'b0, 1'b0);

        // all-zero block
        for (int i = 0; i < 16; i++) blk[i] = 32'h0;
        build_exp();
        do_load(1'b0, 1'b0);
        do_stream(1'b0, 1'b0);

        // backpressure on both sides, stream must match the unstalled one
        set_abc();
        do_load(1'b1, 1'b0);
        do_stream(1'b1, 1'b0);

        // stray start pulses during LOAD and RUN
        do_load(1'b0, 1'b1);
        do_stream(1'b0, 1'b1);

        // reset mid-RUN at t=30
        do_load(1'b0, 1'b0);
        for (int t = 0; t < 30; t++) begin
            next = 1'b1;
            @(negedge clk);
        end
        chk("pre_abort_idx", 32'(out_idx), 32'd30);
        next  = 1'b0;
        reset = 1'b0;
        #1;
        chk("abort_valid", 32'(out_valid), 32'd0);
        chk("abort_w", out_w, 32'd0);
        chk("abort_idx", 32'(out_idx), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("abort_no_done", 32'(done), 32'd0);
            chk("abort_idle", 32'(busy), 32'd0);
        end
        do_load(1'b0, 1'b0);
        do_stream(1'b0, 1'b0);

        // ROUNDS=16 instance emits exactly the loaded words
        for (int i = 0; i < 16; i++) blk[i] = 32'h1000_0001 * (i + 1);
        @(negedge clk); s_start = 1'b1;
        @(negedge clk); s_start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            s_in_valid = 1'b1;
            s_in_w     = blk[i];
            @(negedge clk);
        end
        s_in_valid = 1'b0;
        for (int t = 0; t < 16; t++) begin
            chk("r16_valid", 32'(s_out_valid), 32'd1);
            chk("r16_idx", 32'(s_out_idx), 32'(t));
            chk("r16_w", s_out_w, blk[t]);
            s_next = 1'b1;
            @(negedge clk);
        end
        s_next = 1'b0;
        chk("r16_done", 32'(s_done), 32'd1);
        chk("r16_done_valid", 32'(s_out_valid), 32'd0);
        @(negedge clk);
        chk("r16_done_once", 32'(s_done), 32'd0);
        chk("r16_idle_busy", 32'(s_busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
